bitwise_op_sequencer: RTL

Sequencing controller for the team's 8-bit bitwise logic datapath. It loads operand A and then operand B from the shared `ui_in` bus under a handshake strobe. It then executes one of four bitwise operations and presents the registered result with status flags. An accumulate mode chains results so that a multi-operand reduction needs only one new operand per step.

---
 rtl/bitwise_op_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/bitwise_op_sequencer.sv
// Two-operand bitwise sequencer: strobe-loaded A/B operands, one-cycle execute,
// registered result with status flags, and an accumulate mode that chains results.
module bitwise_op_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {IDLE, WAIT_B, EXEC, DONE} state_t;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  state_t     state_q;
  logic [7:0] a_q, b_q, res_q;
  logic [1:0] op_q;
  logic       stb_s1_q, stb_s2_q, stb_s3_q;
  logic       clr_s1_q, clr_s2_q;
  logic       stb_e;
  logic [7:0] res_d;
  logic       busy, valid;

  // ena and the top control bits carry no function here
  logic unused_w;
  assign unused_w = ^{ena, uio_in[7:5]};

  assign stb_e = stb_s2_q & ~stb_s3_q;

  always_comb begin
    res_d = 8'h00;
    unique case (op_q)
      OP_AND:  res_d = a_q & b_q;
      OP_OR:   res_d = a_q | b_q;
      OP_XOR:  res_d = a_q ^ b_q;
      OP_NAND: res_d = ~(a_q & b_q);
      default: res_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      op_q     <= 2'b00;
      res_q    <= 8'h00;
      stb_s1_q <= 1'b0;
      stb_s2_q <= 1'b0;
      stb_s3_q <= 1'b0;
      clr_s1_q <= 1'b0;
      clr_s2_q <= 1'b0;
    end else begin
      stb_s1_q <= uio_in[0];
      stb_s2_q <= stb_s1_q;
      stb_s3_q <= stb_s2_q;
      clr_s1_q <= uio_in[4];
      clr_s2_q <= clr_s1_q;
      // Clear outranks any strobe edge in the same cycle; that edge is lost.
      if (clr_s2_q) begin
        state_q <= IDLE;
        a_q     <= 8'h00;
        b_q     <= 8'h00;
        op_q    <= 2'b00;
        res_q   <= 8'h00;
      end else begin
        unique case (state_q)
          IDLE: if (stb_e) begin
            a_q     <= ui_in;
            state_q <= WAIT_B;
          end
          WAIT_B: if (stb_e) begin
            b_q     <= ui_in;
            op_q    <= uio_in[2:1];
            state_q <= EXEC;
          end
          EXEC: begin
            res_q   <= res_d;
            state_q <= DONE;
          end
          DONE: if (stb_e) begin
            if (uio_in[3]) begin
              a_q     <= res_q;
              b_q     <= ui_in;
              op_q    <= uio_in[2:1];
              state_q <= EXEC;
            end else begin
              a_q     <= ui_in;
              state_q <= WAIT_B;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy    = (state_q == WAIT_B) | (state_q == EXEC);
  assign valid   = (state_q == DONE);
  assign uo_out  = res_q;
  assign uio_out = {valid & ^res_q, valid & (res_q == 8'h00), valid, busy, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule
